// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans an R x C active-low matrix keypad one column at a time. The row inputs
// are synchronised, sampled once per column dwell and combined into a single
// result for each full scan frame. A result must repeat for DEBOUNCE_FRAMES
// consecutive frames before it is committed. Commits produce press/release
// pulses that carry a raw scan code.
//
// Ports:
//   clk_100MHz   in   system clock
//   reset        in   synchronous, active-high reset
//   row          in   [NUM_ROWS]  keypad rows, active low, asynchronous to clk
//   col          out  [NUM_COLS]  column drive, one-cold
//   key_code     out  [CODE_W]    committed scan code = row_idx*NUM_COLS + col_idx
//   key_valid    out  high while exactly one key is committed as pressed
//   key_press    out  1-cycle pulse when a new key is committed
//   key_release  out  1-cycle pulse when the committed key is released/superseded
//   multi_key    out  high while two or more keys are committed as pressed
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int SCAN_CYCLES     = 100000,
    parameter int SETTLE          = 10,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int CODE_W          = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_press,
    output logic                key_release,
    output logic                multi_key
);

    localparam int TIMER_W = $clog2(SCAN_CYCLES);
    localparam int COL_W   = $clog2(NUM_COLS);
    localparam int ROW_W   = $clog2(NUM_ROWS);
    localparam int CNT_W   = 4;

    // Frame results and the committed state share one encoding so they can be
    // compared directly.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_MULTI
    } state_t;

    // Column index i drives col[NUM_COLS-1-i] low (legacy PMOD pinout).
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
        logic [NUM_COLS-1:0] v;
        for (int i = 0; i < NUM_COLS; i++) begin
            v[i] = (i != (NUM_COLS - 1 - int'(idx)));
        end
        return v;
    endfunction

    logic [NUM_ROWS-1:0] r_row_meta;
    logic [NUM_ROWS-1:0] r_row_sync;
    logic [TIMER_W-1:0]  r_timer;
    logic [COL_W-1:0]    r_col_idx;
    logic [NUM_COLS-1:0] r_col;
    logic [1:0]          r_acc_cnt;
    logic [CODE_W-1:0]   r_acc_code;
    state_t              r_prev_state;
    logic [CODE_W-1:0]   r_prev_code;
    logic [CNT_W-1:0]    r_stable_cnt;
    state_t              r_state;
    logic [CODE_W-1:0]   r_key_code;
    logic                r_key_press;
    logic                r_key_release;

    logic                w_timer_wrap;
    logic                w_col_last;
    logic                w_frame_end;
    logic                w_sample;
    logic [COL_W-1:0]    w_col_idx_nxt;
    logic [1:0]          w_col_cnt;
    logic [ROW_W-1:0]    w_col_row;
    logic [CODE_W-1:0]   w_col_code;
    logic [2:0]          w_sum;
    logic [1:0]          w_acc_cnt;
    logic [CODE_W-1:0]   w_acc_code;
    state_t              w_res_state;
    logic [CODE_W-1:0]   w_res_code;
    logic                w_same;
    logic [CNT_W-1:0]    w_stable_nxt;
    logic                w_commit;
    state_t              w_state_nxt;
    logic [CODE_W-1:0]   w_code_nxt;
    logic                w_press_nxt;
    logic                w_release_nxt;

    assign w_timer_wrap  = (r_timer == TIMER_W'(SCAN_CYCLES - 1));
    assign w_col_last    = (r_col_idx == COL_W'(NUM_COLS - 1));
    assign w_frame_end   = w_timer_wrap && w_col_last;
    assign w_sample      = (r_timer == TIMER_W'(SETTLE));
    assign w_col_idx_nxt = w_col_last ? '0 : r_col_idx + COL_W'(1);

    // Two-flop synchroniser; idle level (all ones) means no key pressed.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Dwell timer and column drive; col changes on the wrap edge.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_timer   <= '0;
            r_col_idx <= '0;
            r_col     <= col_drive('0);
        end else if (w_timer_wrap) begin
            r_timer   <= '0;
            r_col_idx <= w_col_idx_nxt;
            r_col     <= col_drive(w_col_idx_nxt);
        end else begin
            r_timer   <= r_timer + TIMER_W'(1);
        end
    end

    // Pressed keys in the current column: count (saturating at 2) and lowest
    // row index. Scanning downwards leaves the lowest index in w_col_row.
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a variable unassigned (which would infer a latch).
    always_comb begin
        w_col_cnt = '0;
        w_col_row = '0;
        for (int j = NUM_ROWS - 1; j >= 0; j--) begin
            if (!r_row_sync[NUM_ROWS-1-j]) begin
                w_col_row = ROW_W'(j);
                if (w_col_cnt != 2'd2) begin
                    w_col_cnt = w_col_cnt + 2'd1;
                end
            end
        end
        w_col_code = CODE_W'(int'(w_col_row) * NUM_COLS + int'(r_col_idx));
    end

    // Frame accumulator including this cycle's sample, so a sample landing on
    // the frame-end cycle still counts toward that frame.
    always_comb begin
        w_acc_cnt  = r_acc_cnt;
        w_acc_code = r_acc_code;
        w_sum      = {1'b0, r_acc_cnt} + {1'b0, w_col_cnt};
        if (w_sample && (w_col_cnt != 2'd0)) begin
            if ((r_acc_cnt == 2'd0) || (w_col_code < r_acc_code)) begin
                w_acc_code = w_col_code;
            end
            w_acc_cnt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        end
    end

    // Frame result; code is forced to 0 for NONE/MULTI so equality is exact.
    always_comb begin
        w_res_state = ST_IDLE;
        w_res_code  = '0;
        if (w_acc_cnt == 2'd1) begin
            w_res_state = ST_PRESSED;
            w_res_code  = w_acc_code;
        end else if (w_acc_cnt == 2'd2) begin
            w_res_state = ST_MULTI;
        end
    end

    assign w_same       = (w_res_state == r_prev_state) && (w_res_code == r_prev_code);
    assign w_stable_nxt = !w_same ? CNT_W'(1) :
                          (r_stable_cnt == CNT_W'(DEBOUNCE_FRAMES)) ? r_stable_cnt :
                          r_stable_cnt + CNT_W'(1);
    assign w_commit     = w_frame_end && (w_stable_nxt == CNT_W'(DEBOUNCE_FRAMES)) &&
                          ((w_res_state != r_state) ||
                           ((w_res_state == ST_PRESSED) && (w_res_code != r_key_code)));

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_acc_cnt    <= '0;
            r_acc_code   <= '0;
            r_prev_state <= ST_IDLE;
            r_prev_code  <= '0;
            r_stable_cnt <= '0;
        end else if (w_frame_end) begin
            r_acc_cnt    <= '0;
            r_acc_code   <= '0;
            r_prev_state <= w_res_state;
            r_prev_code  <= w_res_code;
            r_stable_cnt <= w_stable_nxt;
        end else begin
            r_acc_cnt    <= w_acc_cnt;
            r_acc_code   <= w_acc_code;
        end
    end

    // Committed-state FSM: state register.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_key_code    <= '0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_key_code    <= w_code_nxt;
            r_key_press   <= w_press_nxt;
            r_key_release <= w_release_nxt;
        end
    end

    // Committed-state FSM: next state. Leaving PRESSED always releases;
    // entering PRESSED always presses (both at once on rollover).
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_key_code;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (w_commit) begin
            w_state_nxt = w_res_state;
            if (w_res_state == ST_PRESSED) begin
                w_code_nxt  = w_res_code;
                w_press_nxt = 1'b1;
            end
            if (r_state == ST_PRESSED) begin
                w_release_nxt = 1'b1;
            end
        end
    end

    // Committed-state FSM: outputs.
    always_comb begin
        col         = r_col;
        key_code    = r_key_code;
        key_valid   = (r_state == ST_PRESSED);
        multi_key   = (r_state == ST_MULTI);
        key_press   = r_key_press;
        key_release = r_key_release;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Drives keypad_scanner through a behavioural key matrix (a pressed key pulls
// its row low while its column is driven). Table vectors hold a key mask for
// whole frames, aligned to frame starts, and check pulse counts and final
// outputs. Hand-written sequences cover reset, column stepping and reset
// while a key is held.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int SC    = 20;
    localparam int FRAME = NC * SC;
    localparam int NV    = 19;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic        valid;
        logic        multi;
        logic [3:0]  code;
        int          presses;
        int          releases;
        int          both;
    } vec_t;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_press;
    logic        key_release;
    logic        multi_key;
    logic [15:0] keys;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [NV];

    keypad_scanner #(
        .NUM_ROWS       (NR),
        .NUM_COLS       (NC),
        .SCAN_CYCLES    (SC),
        .SETTLE         (4),
        .DEBOUNCE_FRAMES(3)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_press  (key_press),
        .key_release(key_release),
        .multi_key  (multi_key)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Key matrix: key (j,i) has code j*NC+i, column i on col[NC-1-i],
    // row j on row[NR-1-j].
    always_comb begin
        row = 4'hF;
        for (int j = 0; j < NR; j++) begin
            for (int i = 0; i < NC; i++) begin
                if (keys[j*NC+i] && !col[NC-1-i]) begin
                    row[NR-1-j] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " col"},         32'(col),         32'h7);
        check({tag, " key_code"},    32'(key_code),    32'h0);
        check({tag, " key_valid"},   32'(key_valid),   32'h0);
        check({tag, " key_press"},   32'(key_press),   32'h0);
        check({tag, " key_release"}, 32'(key_release), 32'h0);
        check({tag, " multi_key"},   32'(multi_key),   32'h0);
    endtask

    initial begin
        logic [3:0] exp_col;
        int np, nr, nb, press_at;

        //           keys      frm valid multi code  p  r  b
        vecs[0]  = '{16'h0040, 2, 1'b0, 1'b0, 4'd0,  0, 0, 0};  // not yet stable
        vecs[1]  = '{16'h0040, 1, 1'b1, 1'b0, 4'd6,  1, 0, 0};  // 3rd frame commits
        vecs[2]  = '{16'h0000, 3, 1'b0, 1'b0, 4'd6,  0, 1, 0};  // release, code holds
        vecs[3]  = '{16'h0040, 1, 1'b0, 1'b0, 4'd6,  0, 0, 0};  // bounce
        vecs[4]  = '{16'h0000, 1, 1'b0, 1'b0, 4'd6,  0, 0, 0};
        vecs[5]  = '{16'h0040, 1, 1'b0, 1'b0, 4'd6,  0, 0, 0};
        vecs[6]  = '{16'h0000, 1, 1'b0, 1'b0, 4'd6,  0, 0, 0};
        vecs[7]  = '{16'h0040, 1, 1'b0, 1'b0, 4'd6,  0, 0, 0};
        vecs[8]  = '{16'h0000, 1, 1'b0, 1'b0, 4'd6,  0, 0, 0};
        vecs[9]  = '{16'h0040, 3, 1'b1, 1'b0, 4'd6,  1, 0, 0};  // steady after bounce
        vecs[10] = '{16'h0240, 3, 1'b0, 1'b1, 4'd6,  0, 1, 0};  // 6+9 -> MULTI
        vecs[11] = '{16'h0040, 3, 1'b1, 1'b0, 4'd6,  1, 0, 0};  // MULTI -> PRESSED(6)
        vecs[12] = '{16'h0008, 3, 1'b1, 1'b0, 4'd3,  1, 1, 1};  // rollover to 3
        vecs[13] = '{16'h1000, 3, 1'b1, 1'b0, 4'd12, 1, 1, 1};  // rollover to 12
        vecs[14] = '{16'h0001, 3, 1'b1, 1'b0, 4'd0,  1, 1, 1};  // lowest code
        vecs[15] = '{16'h8000, 3, 1'b1, 1'b0, 4'd15, 1, 1, 1};  // highest code
        vecs[16] = '{16'h0000, 3, 1'b0, 1'b0, 4'd15, 0, 1, 0};
        vecs[17] = '{16'h0044, 3, 1'b0, 1'b1, 4'd15, 0, 0, 0};  // IDLE -> MULTI, same col
        vecs[18] = '{16'h0000, 3, 1'b0, 1'b0, 4'd15, 0, 0, 0};  // MULTI -> IDLE silently

        // Reset state.
        keys  = 16'h0000;
        reset = 1'b1;
        repeat (5) @(negedge clk_100MHz);
        check_idle_outputs("reset");

        // Column stepping: at the k-th negedge after release the timer is k mod SC.
        reset = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk_100MHz);
            if ((k % SC == 0) || (k % SC == SC - 1)) begin
                exp_col = 4'hF;
                exp_col[NC-1-((k / SC) % NC)] = 1'b0;
                check($sformatf("col step k=%0d", k), 32'(col), 32'(exp_col));
            end
        end

        // Table vectors; each starts on the first cycle of a frame.
        for (int v = 0; v < NV; v++) begin
            keys = vecs[v].keys;
            np = 0;
            nr = 0;
            nb = 0;
            for (int c = 0; c < vecs[v].frames * FRAME; c++) begin
                @(negedge clk_100MHz);
                if (key_press) np++;
                if (key_release) nr++;
                if (key_press && key_release) nb++;
            end
            check($sformatf("vec%0d key_valid", v), 32'(key_valid), 32'(vecs[v].valid));
            check($sformatf("vec%0d multi_key", v), 32'(multi_key), 32'(vecs[v].multi));
            check($sformatf("vec%0d key_code", v),  32'(key_code),  32'(vecs[v].code));
            check($sformatf("vec%0d presses", v),   32'(np),        32'(vecs[v].presses));
            check($sformatf("vec%0d releases", v),  32'(nr),        32'(vecs[v].releases));
            check($sformatf("vec%0d both", v),      32'(nb),        32'(vecs[v].both));
        end

        // Reset while code 6 is committed.
        keys = 16'h0040;
        repeat (3 * FRAME) @(negedge clk_100MHz);
        check("pre-reset key_valid", 32'(key_valid), 32'h1);
        check("pre-reset key_code",  32'(key_code),  32'h6);
        repeat (30) @(negedge clk_100MHz);
        nr = 0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk_100MHz);
            if (key_release) nr++;
        end
        check_idle_outputs("mid reset");
        reset = 1'b0;
        press_at = -1;
        for (int k = 1; k <= 5 * FRAME; k++) begin
            @(negedge clk_100MHz);
            if (key_release) nr++;
            if (key_press) begin
                press_at = k;
                break;
            end
        end
        check("re-press latency", 32'(press_at), 32'(3 * FRAME));
        check("no release across reset", 32'(nr), 32'h0);
        check("re-press key_code",  32'(key_code),  32'h6);
        check("re-press key_valid", 32'(key_valid), 32'h1);
        @(negedge clk_100MHz);
        check("press pulse width", 32'(key_press), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
